// File: rtl/tail_light_input_controller.sv
// Tail-light front end: synchronizes and debounces the driver switches, arbitrates turn requests,
// auto-cancels long turns, and presents request levels that only move on step boundaries.
module tail_light_input_controller #(
  parameter int TICK_DIV     = 4,
  parameter int DEB_LEN      = 3,
  parameter int CANCEL_STEPS = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic brake_sw,
  input  logic hazard_sw,
  input  logic left_sw,
  input  logic right_sw,
  output logic brake,
  output logic hazard,
  output logic left,
  output logic right,
  output logic step,
  output logic turn_active
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
  localparam int CW = (CANCEL_STEPS > 0) ? $clog2(CANCEL_STEPS + 1) : 1;

  localparam int SW_BRAKE  = 0;
  localparam int SW_HAZARD = 1;
  localparam int SW_LEFT   = 2;
  localparam int SW_RIGHT  = 3;

  typedef enum logic [1:0] {
    ST_NONE,
    ST_LEFT,
    ST_RIGHT,
    ST_LOCKOUT
  } turn_state_e;

  logic [3:0]          raw;
  logic [3:0]          sync1, sync2;
  logic [3:0]          deb, deb_q;
  logic [3:0][DW-1:0]  dcnt;
  logic [PW-1:0]       pcnt;
  logic [CW-1:0]       ccnt_q, ccnt_d;
  turn_state_e         state_q, state_d;
  logic                rise_l, rise_r, fall_l, fall_r;

  assign raw = {right_sw, left_sw, hazard_sw, brake_sw};

  // Each switch must disagree with its debounced level for DEB_LEN straight clocks to flip it.
  // NOTE: the small per-switch counter array is reset with everything else; it is a handful of
  // flops, not a RAM, and an unreset count could fire a spurious update right after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      dcnt  <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample pre-edge values, which is what
      // makes sync1 -> sync2 a real two-stage synchronizer rather than a wire.
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DW'(DEB_LEN - 1)) begin
          deb[i]  <= sync2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise_l = deb[SW_LEFT] & ~deb_q[SW_LEFT];
  assign rise_r = deb[SW_RIGHT] & ~deb_q[SW_RIGHT];
  assign fall_l = ~deb[SW_LEFT] & deb_q[SW_LEFT];
  assign fall_r = ~deb[SW_RIGHT] & deb_q[SW_RIGHT];

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
    end else if (pcnt == PW'(TICK_DIV - 1)) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  assign step        = (pcnt == PW'(TICK_DIV - 1));
  assign turn_active = (state_q == ST_LEFT) || (state_q == ST_RIGHT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_NONE;
      ccnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ccnt_q  <= ccnt_d;
    end
  end

  // Switch edges outrank auto-cancel; simultaneous rising edges cancel each other out.
  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    state_d = state_q;
    ccnt_d  = ccnt_q;
    if (rise_l && !rise_r) begin
      state_d = ST_LEFT;
      ccnt_d  = '0;
    end else if (rise_r && !rise_l) begin
      state_d = ST_RIGHT;
      ccnt_d  = '0;
    end else if (rise_l && rise_r) begin
      state_d = state_q;
    end else if ((state_q == ST_LEFT && fall_l) || (state_q == ST_RIGHT && fall_r)) begin
      state_d = ST_NONE;
    end else if (state_q == ST_LOCKOUT && !deb[SW_LEFT] && !deb[SW_RIGHT]) begin
      state_d = ST_NONE;
    end else if (CANCEL_STEPS > 0 && turn_active && step && !deb[SW_HAZARD]) begin
      if (ccnt_q == CW'(CANCEL_STEPS - 1)) begin
        state_d = ST_LOCKOUT;
      end else begin
        ccnt_d = ccnt_q + 1'b1;
      end
    end
  end

  // Outputs move only on step so the sequencer never sees a change mid-pattern.
  always_ff @(posedge clk) begin
    if (reset) begin
      brake  <= 1'b0;
      hazard <= 1'b0;
      left   <= 1'b0;
      right  <= 1'b0;
    end else if (step) begin
      brake  <= deb[SW_BRAKE];
      hazard <= deb[SW_HAZARD];
      left   <= !deb[SW_HAZARD] && (state_q == ST_LEFT);
      right  <= !deb[SW_HAZARD] && (state_q == ST_RIGHT);
    end
  end

endmodule
